// File: rtl/latch_sync_debounce.sv
// latch_sync_debounce: brings the asynchronous latch Q into the clock domain,
// debounces it, emits one-cycle rise/fall pulses and counts accepted transitions.
module latch_sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 q_in,
  input  logic                 clr,
  output logic                 q_stable,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] edge_cnt,
  output logic                 cnt_ovf
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   q_stable_q, q_stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_WIDTH-1:0]   edge_cnt_q, edge_cnt_d;
  logic                   cnt_ovf_q, cnt_ovf_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state logic: synchronizer shift, debounce FSM, pulses and transition counter
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], q_in};
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    q_stable_d = q_stable_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    edge_cnt_d = edge_cnt_q;
    cnt_ovf_d  = cnt_ovf_q;

    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d   = WAIT_HI;
          deb_cnt_d = DEB_ONE;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d   = STABLE_LO;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = STABLE_HI;
          deb_cnt_d  = '0;
          q_stable_d = 1'b1;
          rise_d     = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d   = WAIT_LO;
          deb_cnt_d = DEB_ONE;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d   = STABLE_HI;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = STABLE_LO;
          deb_cnt_d  = '0;
          q_stable_d = 1'b0;
          fall_d     = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end
      default: begin
        state_d   = STABLE_LO;
        deb_cnt_d = '0;
      end
    endcase

    // clr takes priority over a same-edge accepted transition; the pulse still fires
    if (clr) begin
      edge_cnt_d = '0;
      cnt_ovf_d  = 1'b0;
    end else if (rise_d || fall_d) begin
      edge_cnt_d = edge_cnt_q + CNT_ONE;
      if (&edge_cnt_q) begin
        cnt_ovf_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= STABLE_LO;
      deb_cnt_q  <= '0;
      q_stable_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      edge_cnt_q <= '0;
      cnt_ovf_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      q_stable_q <= q_stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_cnt_q <= edge_cnt_d;
      cnt_ovf_q  <= cnt_ovf_d;
    end
  end

  assign q_stable = q_stable_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign edge_cnt = edge_cnt_q;
  assign cnt_ovf  = cnt_ovf_q;

endmodule

// File: tb/tb_latch_sync_debounce.sv
// tb_latch_sync_debounce: directed scenarios plus randomized q_in/clr traffic,
// checked each cycle against a sample-history reference model.
module tb_latch_sync_debounce;

  localparam int SS = 2;
  localparam int DC = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          q_in;
  logic          clr;
  logic          q_stable;
  logic          rise;
  logic          fall;
  logic [CW-1:0] edge_cnt;
  logic          cnt_ovf;

  int tests_run = 0;
  int fail_count = 0;

  // Reference model: a level is accepted once the synchronized sample has
  // disagreed with the current accepted level for DC consecutive samples.
  logic m_sync [SS];
  logic m_stable;
  int   m_run;
  logic m_rise;
  logic m_fall;
  int   m_cnt;
  logic m_ovf;
  logic saw_rise;
  logic saw_pulse;

  latch_sync_debounce #(
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .q_in(q_in),
    .clr(clr),
    .q_stable(q_stable),
    .rise(rise),
    .fall(fall),
    .edge_cnt(edge_cnt),
    .cnt_ovf(cnt_ovf)
  );

  // Free-running clock, 10-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
    m_stable = 1'b0;
    m_run    = 0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_cnt    = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic modelEdge();
    logic s;
    s = m_sync[SS-1];
    for (int i = SS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = q_in;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_stable) begin
      m_run++;
      if (m_run == DC) begin
        m_stable = s;
        m_run    = 0;
        if (s) m_rise = 1'b1;
        else   m_fall = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    if (clr) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (m_rise || m_fall) begin
      if (m_cnt == (1 << CW) - 1) m_ovf = 1'b1;
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_q_stable"}, 32'(q_stable), 32'(m_stable));
    checkOutput({tag, "_rise"},     32'(rise),     32'(m_rise));
    checkOutput({tag, "_fall"},     32'(fall),     32'(m_fall));
    checkOutput({tag, "_edge_cnt"}, 32'(edge_cnt), 32'(m_cnt));
    checkOutput({tag, "_cnt_ovf"},  32'(cnt_ovf),  32'(m_ovf));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_q_stable"}, 32'(q_stable), 32'd0);
    checkOutput({tag, "_rise"},     32'(rise),     32'd0);
    checkOutput({tag, "_fall"},     32'(fall),     32'd0);
    checkOutput({tag, "_edge_cnt"}, 32'(edge_cnt), 32'd0);
    checkOutput({tag, "_cnt_ovf"},  32'(cnt_ovf),  32'd0);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it
  task automatic applyStimulus(input logic q, input logic c, input string tag);
    q_in = q;
    clr  = c;
    @(posedge clk);
    if (!rst_n) modelReset();
    else        modelEdge();
    #1;
    if (rise === 1'b1) saw_rise = 1'b1;
    if (rise === 1'b1 || fall === 1'b1) saw_pulse = 1'b1;
    checkModel(tag);
    checkOutput({tag, "_excl"}, 32'(rise & fall), 32'd0);
  endtask

  initial begin
    logic lvl;
    int   hold;
    rst_n = 1'b1;
    q_in  = 1'b1;
    clr   = 1'b0;
    saw_rise  = 1'b0;
    saw_pulse = 1'b0;
    modelReset();

    // 1: async reset with q_in high, no clock edge involved
    #1 rst_n = 1'b0;
    #1 checkAllZero("t1_reset");
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b0, "t1");
      if (k < 6) checkOutput("t1_early_q_stable", 32'(q_stable), 32'd0);
    end
    checkOutput("t1_rise_at6", 32'(rise), 32'd1);
    checkOutput("t1_q_stable_at6", 32'(q_stable), 32'd1);
    checkOutput("t1_cnt_at6", 32'(edge_cnt), 32'd1);
    applyStimulus(1'b1, 1'b0, "t1");
    checkOutput("t1_rise_one_cycle", 32'(rise), 32'd0);

    // 2: clean fall after holding high
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, "t2_hold");
    for (int k = 1; k <= 6; k++) applyStimulus(1'b0, 1'b0, "t2");
    checkOutput("t2_fall_at6", 32'(fall), 32'd1);
    checkOutput("t2_q_stable", 32'(q_stable), 32'd0);
    checkOutput("t2_cnt", 32'(edge_cnt), 32'd2);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, "t2_hold");
    applyStimulus(1'b0, 1'b1, "t2_clr");
    checkOutput("t2_clr_cnt", 32'(edge_cnt), 32'd0);

    // 3: three-cycle glitch is rejected
    saw_rise = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, "t3_hi");
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, "t3_lo");
    checkOutput("t3_no_rise", 32'(saw_rise), 32'd0);
    checkOutput("t3_q_stable", 32'(q_stable), 32'd0);
    checkOutput("t3_cnt", 32'(edge_cnt), 32'd0);

    // 4: sixteen transitions wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      lvl = (i % 2 == 0);
      for (int k = 0; k < 7; k++) applyStimulus(lvl, 1'b0, "t4");
      if (i == 14) checkOutput("t4_cnt15_no_ovf", 32'(cnt_ovf), 32'd0);
    end
    checkOutput("t4_wrap_cnt", 32'(edge_cnt), 32'd0);
    checkOutput("t4_wrap_ovf", 32'(cnt_ovf), 32'd1);
    applyStimulus(1'b0, 1'b1, "t4_clr");
    checkOutput("t4_clr_ovf", 32'(cnt_ovf), 32'd0);
    checkOutput("t4_clr_cnt", 32'(edge_cnt), 32'd0);

    // 5: clr on the same edge as an accepted rise
    for (int i = 0; i < 4; i++) begin
      lvl = (i % 2 == 0);
      for (int k = 0; k < 7; k++) applyStimulus(lvl, 1'b0, "t5_pre");
    end
    checkOutput("t5_pre_cnt", 32'(edge_cnt), 32'd4);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 1'b0, "t5");
    applyStimulus(1'b1, 1'b1, "t5_clash");
    checkOutput("t5_clash_rise", 32'(rise), 32'd1);
    checkOutput("t5_clash_cnt", 32'(edge_cnt), 32'd0);

    // 6: async reset while waiting to accept a rise, then quiet with q_in low
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b0, "t6_lo");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, "t6_wait");
    #2 rst_n = 1'b0;
    q_in = 1'b0;
    #1 checkAllZero("t6_reset");
    modelReset();
    applyStimulus(1'b0, 1'b0, "t6_inrst");
    #2 rst_n = 1'b1;
    saw_pulse = 1'b0;
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, "t6_quiet");
    checkOutput("t6_no_pulse", 32'(saw_pulse), 32'd0);

    // 7: randomized levels with random hold times and occasional clr
    for (int seg = 0; seg < 60; seg++) begin
      lvl  = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 8));
      for (int k = 0; k < hold; k++)
        applyStimulus(lvl, $urandom_range(0, 15) == 0, "t7");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
